alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, plus two operands.
- Single-op codes return a registered result one cycle after acceptance.
- Shift codes run an iterative 1-bit-per-cycle shifter and hold off the pipeline through a valid/ready handshake.
- Sits between the ID/EX register and the EX/MEM register; the hazard unit uses in_ready as the EX stall and drives flush on a mispredict.

---
 rtl/alu_exec_unit.sv | 152 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the pipeline.
// Single-op codes return a registered result one cycle after acceptance.
// Shift codes use a 1-bit-per-cycle shifter and hold in_ready low while busy.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shKind_e;

  state_e                state_q, state_d;
  shKind_e               shKind_q, shKind_d;
  logic [SHW-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  outValid_q, outValid_d;

  logic                  accept;
  logic                  isShift;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] singleResult;
  logic [DATA_WIDTH-1:0] shiftStep;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = outValid_q;
  assign ALUResult = result_q;

  assign accept  = in_valid && in_ready && !flush;
  assign isShift = (Operation == 4'b1000) || (Operation == 4'b1001) ||
                   (Operation == 4'b1010);
  assign shamt   = SrcB[SHW-1:0];

  // Result of every single-cycle code; reserved codes and shift codes decode to zero here.
  always_comb begin
    singleResult = '0;
    case (Operation)
      4'b0000: singleResult = SrcA & SrcB;
      4'b0001: singleResult = SrcA | SrcB;
      4'b0010: singleResult = SrcA ^ SrcB;
      4'b0011: singleResult = SrcA + SrcB;
      4'b0100: singleResult = SrcA - SrcB;
      4'b0101: singleResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      4'b0110: singleResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      4'b0111: singleResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1011: singleResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      4'b1101: singleResult = SrcB;
      default: singleResult = '0;
    endcase
  end

  // One-bit step of the iterative shifter; SRA replicates the sign bit.
  always_comb begin
    shiftStep = shiftReg_q;
    case (shKind_q)
      SH_LL:   shiftStep = {shiftReg_q[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   shiftStep = {1'b0, shiftReg_q[DATA_WIDTH-1:1]};
      default: shiftStep = {shiftReg_q[DATA_WIDTH-1], shiftReg_q[DATA_WIDTH-1:1]};
    endcase
  end

  // Next-state logic: accept in IDLE, count down in SHIFT, flush aborts the shift.
  always_comb begin
    state_d    = state_q;
    shKind_d   = shKind_q;
    count_d    = count_q;
    shiftReg_d = shiftReg_q;
    result_d   = result_q;
    outValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (isShift && (shamt != '0)) begin
            state_d    = SHIFT;
            count_d    = shamt;
            shiftReg_d = SrcA;
            if (Operation[1:0] == 2'b00) begin
              shKind_d = SH_LL;
            end else if (Operation[1:0] == 2'b01) begin
              shKind_d = SH_RL;
            end else begin
              shKind_d = SH_RA;
            end
          end else begin
            result_d   = isShift ? SrcA : singleResult;
            outValid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          shiftReg_d = shiftStep;
          count_d    = count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            result_d   = shiftStep;
            outValid_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; a mid-shift reset aborts like flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shKind_q   <= SH_LL;
      count_q    <= '0;
      shiftReg_q <= '0;
      result_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shKind_q   <= shKind_d;
      count_q    <= count_d;
      shiftReg_q <= shiftReg_d;
      result_q   <= result_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, a cycle-level
// reference model checked every cycle, and literal expectations.
module tb_alu_exec_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    Operation;
  logic [DW-1:0] SrcA;
  logic [DW-1:0] SrcB;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] ALUResult;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: a pending shift is a result due on a given edge number.
  int          cyc      = 0;
  bit          mPending = 1'b0;
  int          mDue     = 0;
  logic [31:0] mPendRes = '0;
  logic [31:0] mLast    = '0;
  bit          mValid   = 1'b0;
  bit          checkEn  = 1'b0;

  alu_exec_unit #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .flush     (flush),
    .out_valid (out_valid),
    .ALUResult (ALUResult),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Architectural result of an op computed directly from the operation table.
  function automatic logic [31:0] refOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          n;
    n = int'(b[4:0]);
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a ^ b;
      4'd3:    r = a + b;
      4'd4:    r = a - b;
      4'd5:    r = (a == b) ? 32'd1 : 32'd0;
      4'd6:    r = (a != b) ? 32'd1 : 32'd0;
      4'd7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11:   r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd13:   r = b;
      4'd8:    r = a << n;
      4'd9:    r = a >> n;
      4'd10:   r = $unsigned($signed(a) >>> n);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Model update: schedule shift results shamt edges after acceptance, cancel on flush/reset.
  always @(posedge clk) begin : model
    logic [31:0] r;
    int          n;
    r = refOp(Operation, SrcA, SrcB);
    n = int'(SrcB[4:0]);
    cyc    <= cyc + 1;
    mValid <= 1'b0;
    if (reset) begin
      mPending <= 1'b0;
      mLast    <= '0;
    end else if (mPending) begin
      if (flush) begin
        mPending <= 1'b0;
      end else if (mDue == cyc + 1) begin
        mValid   <= 1'b1;
        mLast    <= mPendRes;
        mPending <= 1'b0;
      end
    end else if (in_valid && !flush) begin
      if ((Operation == 4'd8 || Operation == 4'd9 || Operation == 4'd10) && n > 0) begin
        mPending <= 1'b1;
        mDue     <= cyc + 1 + n;
        mPendRes <= r;
      end else begin
        mValid <= 1'b1;
        mLast  <= r;
      end
    end
  end

  // Single comparison: counts, and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.out_valid", {31'd0, out_valid}, {31'd0, mValid});
      checkOutput("model.ALUResult", ALUResult, mLast);
      checkOutput("model.in_ready", {31'd0, in_ready}, {31'd0, !mPending});
      checkOutput("model.busy", {31'd0, busy}, {31'd0, mPending});
    end
  end

  // Drive one cycle of inputs, let one rising edge consume them, then drop valid/flush.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic v, input logic f);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = v;
    flush     = f;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Count edges after an accept until out_valid shows, bounded; -1 on timeout.
  task automatic waitValid(input int maxC, output int c);
    c = -1;
    for (int i = 1; i <= maxC && c < 0; i++) begin
      @(posedge clk);
      #2;
      if (out_valid === 1'b1) c = i;
    end
  endtask

  // Hard stop if the sequence ever hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence with hand-computed expectations.
  initial begin
    int c;
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    Operation = 4'd0;
    SrcA      = '0;
    SrcB      = '0;
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b0;
    checkEn = 1'b1;

    checkOutput("reset.ALUResult", ALUResult, 32'h0);
    checkOutput("reset.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);

    applyStimulus(4'b0011, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0);
    checkOutput("add.valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add.result", ALUResult, 32'h80000000);
    applyStimulus(4'b0100, 32'h0, 32'h1, 1'b1, 1'b0);
    checkOutput("sub.result", ALUResult, 32'hFFFFFFFF);

    applyStimulus(4'b0101, 32'd5, 32'd5, 1'b1, 1'b0);
    checkOutput("eq.result", ALUResult, 32'd1);
    applyStimulus(4'b0110, 32'd5, 32'd5, 1'b1, 1'b0);
    checkOutput("ne.result", ALUResult, 32'd0);
    checkOutput("ne.valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    checkOutput("lt.result", ALUResult, 32'd1);
    applyStimulus(4'b1011, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    checkOutput("ge.result", ALUResult, 32'd0);
    checkOutput("ge.in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(4'b1010, 32'h80000000, 32'd31, 1'b1, 1'b0);
    checkOutput("sra.busy", {31'd0, busy}, 32'd1);
    checkOutput("sra.in_ready", {31'd0, in_ready}, 32'd0);
    waitValid(40, c);
    checkOutput("sra.latency", 32'(c), 32'd31);
    checkOutput("sra.result", ALUResult, 32'hFFFFFFFF);

    applyStimulus(4'b1001, 32'h80000000, 32'd31, 1'b1, 1'b0);
    waitValid(40, c);
    checkOutput("srl.latency", 32'(c), 32'd31);
    checkOutput("srl.result", ALUResult, 32'h00000001);

    applyStimulus(4'b1000, 32'h1, 32'h0, 1'b1, 1'b0);
    checkOutput("sll0.valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sll0.result", ALUResult, 32'h1);

    applyStimulus(4'b0011, 32'd2, 32'd2, 1'b1, 1'b0);
    applyStimulus(4'b1000, 32'h1, 32'd8, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush.held", ALUResult, 32'd4);
    applyStimulus(4'b0011, 32'd2, 32'd3, 1'b1, 1'b0);
    checkOutput("postflush.add", ALUResult, 32'd5);
    checkOutput("postflush.valid", {31'd0, out_valid}, 32'd1);

    applyStimulus(4'b1000, 32'h1, 32'd4, 1'b1, 1'b0);
    idleCycles(3);
    applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("lastflush.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("lastflush.held", ALUResult, 32'd5);
    checkOutput("lastflush.in_ready", {31'd0, in_ready}, 32'd1);
    idleCycles(3);

    applyStimulus(4'b0011, 32'd1, 32'd1, 1'b1, 1'b1);
    checkOutput("idleflush.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("idleflush.held", ALUResult, 32'd5);

    applyStimulus(4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    checkOutput("reserved.valid", {31'd0, out_valid}, 32'd1);
    checkOutput("reserved.result", ALUResult, 32'h0);
    applyStimulus(4'b1101, 32'hDEADBEEF, 32'h12345000, 1'b1, 1'b0);
    checkOutput("passb.result", ALUResult, 32'h12345000);

    applyStimulus(4'b1010, 32'h80000000, 32'd31, 1'b1, 1'b0);
    idleCycles(5);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("midreset.result", ALUResult, 32'h0);
    checkOutput("midreset.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset.in_ready", {31'd0, in_ready}, 32'd1);
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
